// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one registered-input integer ALU between NREQ requesters. A
// round-robin arbiter picks one eligible requester per cycle and drives its
// operands onto the ALU bus. The single operation in flight is tracked. Its
// result, valid one cycle later, is steered into that requester's one-entry
// response buffer. The buffer is drained with a valid/ready handshake.
//
// Ports:
//   i_clk, i_rst_n          clock (posedge) / asynchronous active-low reset
//   i_req_valid/o_req_ready per-requester request handshake (one-hot grant)
//   i_req_instr..i_req_tag  packed per-requester opcode/operands/PC/tag
//   o_alu_*                 operand bus to the ALU (all zero when idle)
//   i_alu_out               ALU result, valid the cycle after the operands
//   o_resp_valid/i_resp_ready  per-requester response handshake
//   o_resp_data, o_resp_tag packed results and echoed tags
//   o_perf_grant, o_perf_stall  per-requester saturating 32-bit counters
//                           (present only with ALU_ARB_PERF_EN defined)
//
// Optional feature macro: ALU_ARB_PERF_EN
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2,
  parameter int TAG_W = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NREQ-1:0]         i_req_valid,
  output logic [NREQ-1:0]         o_req_ready,
  input  logic [NREQ*6-1:0]       i_req_instr,
  input  logic [NREQ*WIDTH-1:0]   i_req_rs1,
  input  logic [NREQ*WIDTH-1:0]   i_req_rs2,
  input  logic [NREQ*WIDTH-1:0]   i_req_imm,
  input  logic [NREQ*5-1:0]       i_req_shamt,
  input  logic [NREQ*32-1:0]      i_req_pc,
  input  logic [NREQ*TAG_W-1:0]   i_req_tag,
  output logic [5:0]              o_alu_instr,
  output logic [WIDTH-1:0]        o_alu_rs1,
  output logic [WIDTH-1:0]        o_alu_rs2,
  output logic [WIDTH-1:0]        o_alu_imm,
  output logic [4:0]              o_alu_shamt,
  output logic [31:0]             o_alu_pc,
  input  logic [WIDTH-1:0]        i_alu_out,
  output logic [NREQ-1:0]         o_resp_valid,
  input  logic [NREQ-1:0]         i_resp_ready,
  output logic [NREQ*WIDTH-1:0]   o_resp_data,
  output logic [NREQ*TAG_W-1:0]   o_resp_tag
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [NREQ*32-1:0]      o_perf_grant,
  output logic [NREQ*32-1:0]      o_perf_stall
`endif
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0]         r_rr_ptr;
  logic                   r_infl_v;
  logic [IDW-1:0]         r_infl_id;
  logic [TAG_W-1:0]       r_infl_tag;
  logic [NREQ-1:0]        r_resp_valid;
  logic [NREQ*WIDTH-1:0]  r_resp_data;
  logic [NREQ*TAG_W-1:0]  r_resp_tag;

  logic [NREQ-1:0]        w_eligible;
  logic [NREQ-1:0]        w_grant;
  logic [IDW-1:0]         w_grant_id;
  logic [IDW-1:0]         w_next_ptr;
  logic [TAG_W-1:0]       w_grant_tag;
  logic                   w_found;

  // A requester may not issue while its own op is in flight, nor while its
  // buffer holds a response that is not being drained this cycle. This is
  // what guarantees a capture never overwrites an unconsumed response.
  always_comb begin
    w_eligible = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_eligible[k] = i_req_valid[k]
                    & ~(r_infl_v & (r_infl_id == IDW'(k)))
                    & (~r_resp_valid[k] | i_resp_ready[k]);
    end
  end

  // Round-robin search starting at r_rr_ptr. Grants are forced off while
  // reset is asserted.
  always_comb begin
    w_grant    = '0;
    w_grant_id = '0;
    w_found    = 1'b0;
    if (i_rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && w_eligible[(int'(r_rr_ptr) + i) % NREQ]) begin
          w_found    = 1'b1;
          w_grant_id = IDW'((int'(r_rr_ptr) + i) % NREQ);
          w_grant[(int'(r_rr_ptr) + i) % NREQ] = 1'b1;
        end
      end
    end
  end

  assign w_next_ptr  = (w_grant_id == IDW'(NREQ - 1)) ? '0 : w_grant_id + 1'b1;
  assign o_req_ready = w_grant;

  // The operand bus is zero (ALU default opcode) when nothing is granted.
  always_comb begin
    o_alu_instr = '0;
    o_alu_rs1   = '0;
    o_alu_rs2   = '0;
    o_alu_imm   = '0;
    o_alu_shamt = '0;
    o_alu_pc    = '0;
    w_grant_tag = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_grant[k]) begin
        o_alu_instr = i_req_instr[k*6 +: 6];
        o_alu_rs1   = i_req_rs1[k*WIDTH +: WIDTH];
        o_alu_rs2   = i_req_rs2[k*WIDTH +: WIDTH];
        o_alu_imm   = i_req_imm[k*WIDTH +: WIDTH];
        o_alu_shamt = i_req_shamt[k*5 +: 5];
        o_alu_pc    = i_req_pc[k*32 +: 32];
        w_grant_tag = i_req_tag[k*TAG_W +: TAG_W];
      end
    end
  end

  // In-flight tracking and response capture. A capture takes priority over a
  // drain of the same buffer, so the new result stays visible.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr     <= '0;
      r_infl_v     <= 1'b0;
      r_infl_id    <= '0;
      r_infl_tag   <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_resp_tag   <= '0;
    end else begin
      r_infl_v   <= |w_grant;
      r_infl_id  <= w_grant_id;
      r_infl_tag <= w_grant_tag;
      if (|w_grant) begin
        r_rr_ptr <= w_next_ptr;
      end
      for (int k = 0; k < NREQ; k++) begin
        if (r_infl_v && (r_infl_id == IDW'(k))) begin
          r_resp_valid[k]                 <= 1'b1;
          r_resp_data[k*WIDTH +: WIDTH]   <= i_alu_out;
          r_resp_tag[k*TAG_W +: TAG_W]    <= r_infl_tag;
        end else if (i_resp_ready[k]) begin
          r_resp_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;
  assign o_resp_tag   = r_resp_tag;

`ifdef ALU_ARB_PERF_EN
  logic [NREQ*32-1:0] r_perf_grant;
  logic [NREQ*32-1:0] r_perf_stall;

  // Saturating grant/stall counters; a stall is a valid request not granted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_grant <= '0;
      r_perf_stall <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (w_grant[k] && (r_perf_grant[k*32 +: 32] != 32'hFFFF_FFFF)) begin
          r_perf_grant[k*32 +: 32] <= r_perf_grant[k*32 +: 32] + 32'd1;
        end
        if (i_req_valid[k] && !w_grant[k] &&
            (r_perf_stall[k*32 +: 32] != 32'hFFFF_FFFF)) begin
          r_perf_stall[k*32 +: 32] <= r_perf_stall[k*32 +: 32] + 32'd1;
        end
      end
    end
  end

  assign o_perf_grant = r_perf_grant;
  assign o_perf_stall = r_perf_stall;
`endif

endmodule
